// File: rtl/rv16_pkg.sv
// Shared types for the rv16 operand dispatch slice.
// Opcode names, slot states and the issued packet layout.
package rv16_pkg;

    localparam int RV16_DATA   = 16;
    localparam int RV16_OPCODE = 4;
    localparam int RV16_RD_W   = 3;
    localparam int RV16_NUM_FU = 7;

    typedef enum logic [RV16_OPCODE-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_XOR = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6
    } op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [RV16_DATA-1:0] rs1;
        logic [RV16_DATA-1:0] rs2;
        logic [RV16_RD_W-1:0] rd;
    } pkt_t;

endpackage

// File: rtl/rv16_fu_slot.sv
// One-entry EMPTY/FULL holding register for a single FU channel.
// Data flops are cleared whenever the slot empties, so outputs read zero.
module rv16_fu_slot
    import rv16_pkg::*;
#(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic         fu_ready,
    input  logic [W-1:0] load_data,
    output logic         fu_valid,
    output logic [W-1:0] fu_data
);

    slot_state_e state;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state   <= SLOT_EMPTY;
            fu_data <= '0;
        end else if (load) begin
            state   <= SLOT_FULL;
            fu_data <= load_data;
        end else if (state == SLOT_FULL && fu_ready) begin
            state   <= SLOT_EMPTY;
            fu_data <= '0;
        end
    end

    assign fu_valid = (state == SLOT_FULL);

endmodule

// File: rtl/rv16_fu_dispatch.sv
// Registered operand dispatch to NUM_FU functional-unit channels.
// Optional per-channel handshake counters: define RV16_DISPATCH_PERF_EN.
module rv16_fu_dispatch
    import rv16_pkg::*;
#(
    parameter int DATA   = RV16_DATA,
    parameter int OPCODE = RV16_OPCODE,
    parameter int RD_W   = RV16_RD_W,
    parameter int NUM_FU = RV16_NUM_FU
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [OPCODE-1:0]      issue_opcode,
    input  logic [DATA-1:0]        issue_rs1,
    input  logic [DATA-1:0]        issue_rs2,
    input  logic [RD_W-1:0]        issue_rd,
    input  logic                   flush,
    output logic [NUM_FU-1:0]      fu_valid,
    input  logic [NUM_FU-1:0]      fu_ready,
    output logic [NUM_FU*DATA-1:0] fu_rs1,
    output logic [NUM_FU*DATA-1:0] fu_rs2,
    output logic [NUM_FU*RD_W-1:0] fu_rd,
    output logic                   illegal_op
`ifdef RV16_DISPATCH_PERF_EN
   ,output logic [NUM_FU*16-1:0]   perf_cnt
`endif
);

    localparam int W = 2*DATA + RD_W;

    logic              legal;
    logic              sel_ready;
    logic              accept;
    logic [NUM_FU-1:0] load;
    logic [W-1:0]      issue_data;
    logic [W-1:0]      slot_data [NUM_FU];

    always_comb begin
        legal     = 1'b0;
        sel_ready = 1'b0;
        load      = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (int'(issue_opcode) == k) begin
                legal     = 1'b1;
                sel_ready = ~fu_valid[k] | fu_ready[k];
                load[k]   = accept;
            end
        end
    end

    // Out-of-range opcodes are always taken so they can be dropped and flagged.
    assign issue_ready = ~flush & (~legal | sel_ready);
    assign accept      = issue_valid & issue_ready;
    assign issue_data  = {issue_rs1, issue_rs2, issue_rd};

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= accept & ~legal;
        end
    end

    for (genvar k = 0; k < NUM_FU; k++) begin : g_slot
        rv16_fu_slot #(
            .W (W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .load      (load[k]),
            .fu_ready  (fu_ready[k]),
            .load_data (issue_data),
            .fu_valid  (fu_valid[k]),
            .fu_data   (slot_data[k])
        );

        assign fu_rs1[k*DATA +: DATA] = slot_data[k][W-1 -: DATA];
        assign fu_rs2[k*DATA +: DATA] = slot_data[k][RD_W +: DATA];
        assign fu_rd[k*RD_W +: RD_W]  = slot_data[k][RD_W-1:0];
    end

`ifdef RV16_DISPATCH_PERF_EN
    for (genvar k = 0; k < NUM_FU; k++) begin : g_perf
        logic [15:0] cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (fu_valid[k] && fu_ready[k] && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end

        assign perf_cnt[k*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_rv16_fu_dispatch.sv
// Table-driven bench for rv16_fu_dispatch with an output scoreboard.
// Define RV16_DISPATCH_PERF_EN to also exercise the perf counters.
module tb_rv16_fu_dispatch;
    import rv16_pkg::*;

    localparam int NF = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid;
    logic            issue_ready;
    logic [3:0]      issue_opcode;
    logic [15:0]     issue_rs1;
    logic [15:0]     issue_rs2;
    logic [2:0]      issue_rd;
    logic            flush;
    logic [NF-1:0]   fu_valid;
    logic [NF-1:0]   fu_ready;
    logic [NF*16-1:0] fu_rs1;
    logic [NF*16-1:0] fu_rs2;
    logic [NF*3-1:0] fu_rd;
    logic            illegal_op;
`ifdef RV16_DISPATCH_PERF_EN
    logic [NF*16-1:0] perf_cnt;
`endif

    always #5 clk = ~clk;

    rv16_fu_dispatch dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_opcode (issue_opcode),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .fu_valid     (fu_valid),
        .fu_ready     (fu_ready),
        .fu_rs1       (fu_rs1),
        .fu_rs2       (fu_rs2),
        .fu_rd        (fu_rd),
        .illegal_op   (illegal_op)
`ifdef RV16_DISPATCH_PERF_EN
       ,.perf_cnt     (perf_cnt)
`endif
    );

    typedef struct {
        logic      valid;
        logic [3:0] op;
        pkt_t      pkt;
        logic      fl;
        logic [6:0] rdy;
        logic      exp_ready;
    } vec_t;

    typedef struct {
        logic [NF-1:0]    v;
        logic [NF*16-1:0] rs1;
        logic [NF*16-1:0] rs2;
        logic [NF*3-1:0]  rd;
        logic             ill;
    } exp_t;

    vec_t tbl [17];
    exp_t sb [$];

    logic        mfull [NF];
    logic [15:0] mrs1  [NF];
    logic [15:0] mrs2  [NF];
    logic [2:0]  mrd   [NF];
    logic        mill;

    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(logic v, logic [3:0] op, logic [15:0] a,
                                logic [15:0] b, logic [2:0] d, logic fl,
                                logic [6:0] rdy, logic er);
        vec_t t;
        t.valid     = v;
        t.op        = op;
        t.pkt.rs1   = a;
        t.pkt.rs2   = b;
        t.pkt.rd    = d;
        t.fl        = fl;
        t.rdy       = rdy;
        t.exp_ready = er;
        return t;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.v   = '0;
        e.rs1 = '0;
        e.rs2 = '0;
        e.rd  = '0;
        for (int k = 0; k < NF; k++) begin
            e.v[k]          = mfull[k];
            e.rs1[k*16+:16] = mrs1[k];
            e.rs2[k*16+:16] = mrs2[k];
            e.rd[k*3+:3]    = mrd[k];
        end
        e.ill = mill;
        return e;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NF; k++) begin
            mfull[k] = 1'b0;
            mrs1[k]  = '0;
            mrs2[k]  = '0;
            mrd[k]   = '0;
        end
        mill = 1'b0;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        logic acc;
        exp_t e;
        exp_t got;
        @(negedge clk);
        issue_valid  = t.valid;
        issue_opcode = t.op;
        issue_rs1    = t.pkt.rs1;
        issue_rs2    = t.pkt.rs2;
        issue_rd     = t.pkt.rd;
        flush        = t.fl;
        fu_ready     = t.rdy;
        #1;
        chk($sformatf("issue_ready[%0d]", idx), 128'(issue_ready), 128'(t.exp_ready));
        acc = t.valid & t.exp_ready;
        if (t.fl) begin
            model_clear();
        end else begin
            for (int k = 0; k < NF; k++) begin
                if (acc && int'(t.op) == k) begin
                    mfull[k] = 1'b1;
                    mrs1[k]  = t.pkt.rs1;
                    mrs2[k]  = t.pkt.rs2;
                    mrd[k]   = t.pkt.rd;
                end else if (mfull[k] && t.rdy[k]) begin
                    mfull[k] = 1'b0;
                    mrs1[k]  = '0;
                    mrs2[k]  = '0;
                    mrd[k]   = '0;
                end
            end
            mill = acc && int'(t.op) >= NF;
        end
        sb.push_back(snap());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        got.v   = fu_valid;
        got.rs1 = fu_rs1;
        got.rs2 = fu_rs2;
        got.rd  = fu_rd;
        got.ill = illegal_op;
        chk($sformatf("fu_valid[%0d]", idx), 128'(got.v), 128'(e.v));
        chk($sformatf("fu_rs1[%0d]", idx), 128'(got.rs1), 128'(e.rs1));
        chk($sformatf("fu_rs2[%0d]", idx), 128'(got.rs2), 128'(e.rs2));
        chk($sformatf("fu_rd[%0d]", idx), 128'(got.rd), 128'(e.rd));
        chk($sformatf("illegal_op[%0d]", idx), 128'(got.ill), 128'(e.ill));
    endtask

    initial begin
        tbl[0]  = mk(1, 4'd0, 16'h1234, 16'h0001, 3'd3, 0, 7'h7F, 1);
        tbl[1]  = mk(0, 4'd0, 16'h0000, 16'h0000, 3'd0, 0, 7'h7F, 1);
        tbl[2]  = mk(1, 4'd2, 16'hAAAA, 16'h5555, 3'd5, 0, 7'h7B, 1);
        tbl[3]  = mk(1, 4'd2, 16'hBBBB, 16'h6666, 3'd6, 0, 7'h7B, 0);
        tbl[4]  = mk(1, 4'd2, 16'hBBBB, 16'h6666, 3'd6, 0, 7'h7F, 1);
        tbl[5]  = mk(1, 4'd4, 16'hC0DE, 16'h0F0F, 3'd1, 0, 7'h6B, 1);
        tbl[6]  = mk(1, 4'hF, 16'hDEAD, 16'hBEEF, 3'd7, 0, 7'h6B, 1);
        tbl[7]  = mk(0, 4'd0, 16'h0000, 16'h0000, 3'd0, 0, 7'h6B, 1);
        tbl[8]  = mk(1, 4'd1, 16'h1111, 16'h2222, 3'd2, 0, 7'h00, 1);
        tbl[9]  = mk(1, 4'd5, 16'h5555, 16'h3333, 3'd4, 0, 7'h00, 1);
        tbl[10] = mk(1, 4'd3, 16'h3333, 16'h4444, 3'd1, 1, 7'h7F, 0);
        tbl[11] = mk(1, 4'd3, 16'h3333, 16'h4444, 3'd1, 0, 7'h00, 1);
        tbl[12] = mk(1, 4'd3, 16'h9999, 16'h8888, 3'd0, 0, 7'h00, 0);
        tbl[13] = mk(1, 4'd7, 16'hFFFF, 16'hFFFF, 3'd7, 0, 7'h00, 1);
        tbl[14] = mk(1, 4'd6, 16'h7777, 16'h0001, 3'd2, 0, 7'h40, 1);
        tbl[15] = mk(1, 4'd6, 16'h7778, 16'h0002, 3'd3, 0, 7'h40, 1);
        tbl[16] = mk(0, 4'd0, 16'h0000, 16'h0000, 3'd0, 0, 7'h7F, 1);

        rst          = 1'b1;
        issue_valid  = 1'b0;
        issue_opcode = '0;
        issue_rs1    = '0;
        issue_rs2    = '0;
        issue_rd     = '0;
        flush        = 1'b0;
        fu_ready     = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset fu_valid", 128'(fu_valid), 128'(0));
        chk("reset fu_rs1", 128'(fu_rs1), 128'(0));
        chk("reset fu_rs2", 128'(fu_rs2), 128'(0));
        chk("reset fu_rd", 128'(fu_rd), 128'(0));
        chk("reset illegal_op", 128'(illegal_op), 128'(0));
        chk("reset issue_ready", 128'(issue_ready), 128'(1));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_vec(tbl[i], i);
        end
        chk("scoreboard drained", 128'(sb.size()), 128'(0));

`ifdef RV16_DISPATCH_PERF_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        issue_valid  = 1'b1;
        issue_opcode = 4'd6;
        fu_ready     = 7'h7F;
        repeat (3) @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("perf_cnt[6] three", 128'(perf_cnt[6*16+:16]), 128'(3));
        chk("perf_cnt[0] idle", 128'(perf_cnt[0+:16]), 128'(0));
        @(negedge clk);
        issue_valid = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk("perf_cnt[6] saturate", 128'(perf_cnt[6*16+:16]), 128'(16'hFFFF));
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("perf_cnt[6] flush keeps", 128'(perf_cnt[6*16+:16]), 128'(16'hFFFF));
        @(negedge clk);
        flush       = 1'b0;
        issue_valid = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
